sc_speed_scheduler: RTL and testbench
=====================================

Name: sc_speed_scheduler

Overview:
- Parametrised game-speed scheduler for the RoadFighter datapath.
- Maps the current level count onto one of TIERS speed tiers and emits a periodic one-cycle LOAD pulse at that tier's period.
- Drives the one-hot mux select for the datapath speed muxes, and flags tier changes and game completion to the top-level controller.

Parameters:
- TIERS, 3: number of speed tiers (1..8).
- LEVEL_WIDTH, 8: width of the level count input.
- PERIOD_WIDTH, 32: width of the period constants and the tick counter.
- TIER_MAX_LEVEL, {8'd59,8'd32,8'd10}: packed TIERS×LEVEL_WIDTH; inclusive upper level of each tier, ascending, tier 0 in the LSBs.
- TIER_PERIOD, {32'd12500000,32'd15000000,32'd17500000}: packed TIERS×PERIOD_WIDTH; clock cycles per LOAD pulse for each tier (0.35/0.30/0.25 s at 50 MHz).

Ports:
- SC_SPEEDSCHED_CLOCK_50  in  1  system clock, 50 MHz.
- SC_SPEEDSCHED_RESET_InLow  in  1  asynchronous active-low reset.
- SC_SPEEDSCHED_START_InLow  in  1  start request, active low, level-sensitive.
- SC_SPEEDSCHED_CLEAR_InHigh  in  1  synchronous soft clear back to IDLE.
- SC_SPEEDSCHED_PAUSE_InHigh  in  1  freezes the tick counter.
- SC_SPEEDSCHED_LEVEL  in  LEVEL_WIDTH  current level count.
- SC_SPEEDSCHED_LOAD_OutHigh  out  1  one-cycle load strobe.
- SC_SPEEDSCHED_MUXSEL  out  TIERS  one-hot tier select.
- SC_SPEEDSCHED_TIER  out  3  binary tier index.
- SC_SPEEDSCHED_TIERCHG_OutHigh  out  1  one-cycle pulse on each tier change.
- SC_SPEEDSCHED_RUNNING_OutHigh  out  1  high in RUN and PAUSE.
- SC_SPEEDSCHED_DONE_OutHigh  out  1  level is beyond the last tier.

Behaviour:
- Reset (async, RESET_InLow=0):
  - state=IDLE, counter=0, tier_q=0.
  - LOAD=0, TIERCHG=0, RUNNING=0, DONE=0, TIER=0, MUXSEL=0 (all zeros; no select in IDLE).
- Reset mid-operation aborts immediately and asynchronously; no pulse is emitted on release.
- Tier decode (combinational on LEVEL):
  - tier = lowest i with LEVEL <= TIER_MAX_LEVEL[i].
  - If LEVEL > TIER_MAX_LEVEL[TIERS-1], then beyond=1.
- Effective period p = TIER_PERIOD[tier]; p==0 is treated as 1.
- States: IDLE, RUN, PAUSE, DONE. Registered outputs, all with one-cycle latency from the deciding edge.
- IDLE:
  - START_InLow=0 goes to RUN; counter=0, tier_q=tier, MUXSEL=1<<tier. No TIERCHG is issued on entry.
  - If beyond=1 at start, go to DONE instead.
- RUN:
  - counter increments each cycle.
  - When counter==p-1: LOAD=1 for one cycle, counter=0. With p=1, LOAD is high every cycle.
  - PAUSE_InHigh=1 goes to PAUSE.
  - beyond=1 goes to DONE.
- Tier change in RUN (tier != tier_q):
  - tier_q=tier, MUXSEL updated, TIERCHG=1 for one cycle, counter=0.
  - LOAD is suppressed in that cycle, even if the terminal count coincided.
- PAUSE:
  - Counter holds; LOAD=0.
  - Tier changes are still tracked (TIERCHG pulses, counter zeroed).
  - PAUSE_InHigh=0 returns to RUN.
- DONE:
  - DONE=1, LOAD=0, counter=0, MUXSEL holds the last tier.
  - Leaves DONE only on CLEAR or reset.
- Priority: reset > CLEAR > beyond > tier change > PAUSE > terminal count.
- CLEAR_InHigh=1 from any state goes to IDLE, with all outputs at their reset values on the next cycle.
- Counter comparison is unsigned and PERIOD_WIDTH wide. The counter never wraps past p-1; if p shrinks below the counter on a change, the zeroing covers it.
- START is ignored outside IDLE.

Optional Feature:
- Macro: SC_SPEEDSCHED_BOOST_EN.
- With the macro defined:
  - Adds input SC_SPEEDSCHED_BOOST_InHigh (1 bit).
  - While it is high, the effective period is max(p>>1,1).
  - A boost edge does not reset the counter. If counter >= the new p-1, LOAD fires on the next cycle and the counter returns to 0.
- Without the macro: the port is absent and the period is always p.

Decomposition:
- Package sc_speedsched_pkg:
  - state enum {IDLE,RUN,PAUSE,DONE};
  - default period constants CLK50_P350MS/P300MS/P250MS;
  - tier-index width constant.
- Sub-module sc_speedsched_tick_counter (PERIOD_WIDTH):
  - inputs: clock, reset, enable, clear, period;
  - output: terminal-count strobe.
- Tier decode and FSM stay in the top module.

Test Plan (override TIER_MAX_LEVEL={7,5,2}, TIER_PERIOD={2,3,4}):
- Reset held, then released with START high -> all outputs 0, stays IDLE for 20 cycles.
- LEVEL=1, START=0 -> RUNNING=1 next cycle, MUXSEL=001, LOAD every 4th cycle, first LOAD 4 cycles after RUN entry.
- In RUN, LEVEL 1->3 on the cycle of a terminal count -> TIERCHG=1, LOAD=0 that cycle, MUXSEL=010, next LOAD 3 cycles later.
- PAUSE=1 for 5 cycles at counter=1 in tier 0 -> no LOAD while paused; after release, LOAD 3 cycles later; TIERCHG still fires if LEVEL changes mid-pause.
- LEVEL=8 in RUN -> DONE=1, LOAD stops, MUXSEL holds 100; CLEAR=1 -> IDLE, all outputs 0.
- Reset asserted mid-RUN with counter=2 -> outputs 0 asynchronously; with BOOST_EN defined, BOOST=1 in tier 0 -> LOAD every 2 cycles.

Source files
------------

// File: rtl/sc_speedsched_pkg.sv
// ============================================================================
// sc_speedsched_pkg : shared types and default periods for the speed scheduler
// Revision: 1.0
// ============================================================================
`default_nettype none

package sc_speedsched_pkg;

  localparam int TIER_IDX_W = 3;

  // Default tier periods in 50 MHz clock cycles.
  localparam logic [31:0] CLK50_P350MS = 32'd17_500_000;
  localparam logic [31:0] CLK50_P300MS = 32'd15_000_000;
  localparam logic [31:0] CLK50_P250MS = 32'd12_500_000;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    DONE  = 2'd3
  } state_t;

endpackage

`default_nettype wire

// File: rtl/sc_speedsched_tick_counter.sv
// ============================================================================
// sc_speedsched_tick_counter : free-running period counter with terminal strobe
// Revision: 1.0
// ============================================================================
`default_nettype none

module sc_speedsched_tick_counter #(
  parameter int PERIOD_WIDTH = 32
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    i_en,
  input  logic                    i_clear,
  input  logic [PERIOD_WIDTH-1:0] i_period,
  output logic                    o_tc
);

  logic [PERIOD_WIDTH-1:0] r_count;
  logic                    w_at_end;

  // ">=" lets a period that shrinks under the count fire at once instead of wrapping.
  assign w_at_end = (r_count >= (i_period - PERIOD_WIDTH'(1)));
  assign o_tc     = i_en & w_at_end;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (i_clear || o_tc) begin
      r_count <= '0;
    end else if (i_en) begin
      r_count <= r_count + PERIOD_WIDTH'(1);
    end
  end

endmodule

`default_nettype wire

// File: rtl/sc_speed_scheduler.sv
// ============================================================================
// sc_speed_scheduler : level-to-tier decode, LOAD pacing and tier mux select.
// Optional boost input enabled by macro SC_SPEEDSCHED_BOOST_EN.
// Revision: 1.0
// ============================================================================
`default_nettype none

module sc_speed_scheduler
  import sc_speedsched_pkg::*;
#(
  parameter int                              TIERS          = 3,
  parameter int                              LEVEL_WIDTH    = 8,
  parameter int                              PERIOD_WIDTH   = 32,
  parameter logic [TIERS*LEVEL_WIDTH-1:0]    TIER_MAX_LEVEL = {8'd59, 8'd32, 8'd10},
  parameter logic [TIERS*PERIOD_WIDTH-1:0]   TIER_PERIOD    = {CLK50_P250MS, CLK50_P300MS, CLK50_P350MS}
) (
  input  logic                   SC_SPEEDSCHED_CLOCK_50,
  input  logic                   SC_SPEEDSCHED_RESET_InLow,
  input  logic                   SC_SPEEDSCHED_START_InLow,
  input  logic                   SC_SPEEDSCHED_CLEAR_InHigh,
  input  logic                   SC_SPEEDSCHED_PAUSE_InHigh,
`ifdef SC_SPEEDSCHED_BOOST_EN
  input  logic                   SC_SPEEDSCHED_BOOST_InHigh,
`endif
  input  logic [LEVEL_WIDTH-1:0] SC_SPEEDSCHED_LEVEL,
  output logic                   SC_SPEEDSCHED_LOAD_OutHigh,
  output logic [TIERS-1:0]       SC_SPEEDSCHED_MUXSEL,
  output logic [2:0]             SC_SPEEDSCHED_TIER,
  output logic                   SC_SPEEDSCHED_TIERCHG_OutHigh,
  output logic                   SC_SPEEDSCHED_RUNNING_OutHigh,
  output logic                   SC_SPEEDSCHED_DONE_OutHigh
);

  state_t                  r_state, w_state_nxt;
  logic [TIER_IDX_W-1:0]   r_tier_q, w_tier_q_nxt;
  logic [TIERS-1:0]        r_muxsel, w_muxsel_nxt;
  logic                    r_load, w_load_nxt;
  logic                    r_tierchg, w_tierchg_nxt;

  logic [TIER_IDX_W-1:0]   w_tier;
  logic                    w_beyond;
  logic [TIERS-1:0]        w_onehot;
  logic [PERIOD_WIDTH-1:0] w_p_base, w_p_eff, w_period;
  logic                    w_cnt_en, w_cnt_clr, w_tc;

  // Beyond the last tier the index clamps to the top tier.
  always_comb begin
    w_tier = TIER_IDX_W'(TIERS - 1);
    for (int i = TIERS - 1; i >= 0; i--) begin
      if (SC_SPEEDSCHED_LEVEL <= TIER_MAX_LEVEL[i*LEVEL_WIDTH +: LEVEL_WIDTH]) begin
        w_tier = TIER_IDX_W'(i);
      end
    end
  end

  assign w_beyond = (SC_SPEEDSCHED_LEVEL > TIER_MAX_LEVEL[(TIERS-1)*LEVEL_WIDTH +: LEVEL_WIDTH]);

  always_comb begin
    w_onehot = '0;
    w_p_base = '0;
    for (int i = 0; i < TIERS; i++) begin
      w_onehot[i] = (w_tier == TIER_IDX_W'(i));
      if (r_tier_q == TIER_IDX_W'(i)) begin
        w_p_base = TIER_PERIOD[i*PERIOD_WIDTH +: PERIOD_WIDTH];
      end
    end
  end

  assign w_p_eff = (w_p_base == '0) ? PERIOD_WIDTH'(1) : w_p_base;

`ifdef SC_SPEEDSCHED_BOOST_EN
  logic [PERIOD_WIDTH-1:0] w_p_half;
  assign w_p_half = w_p_eff >> 1;
  assign w_period = !SC_SPEEDSCHED_BOOST_InHigh ? w_p_eff :
                    (w_p_half == '0)            ? PERIOD_WIDTH'(1) : w_p_half;
`else
  assign w_period = w_p_eff;
`endif

  sc_speedsched_tick_counter #(
    .PERIOD_WIDTH (PERIOD_WIDTH)
  ) u_tick_counter (
    .clk      (SC_SPEEDSCHED_CLOCK_50),
    .rst_n    (SC_SPEEDSCHED_RESET_InLow),
    .i_en     (w_cnt_en),
    .i_clear  (w_cnt_clr),
    .i_period (w_period),
    .o_tc     (w_tc)
  );

  always_comb begin
    w_state_nxt   = r_state;
    w_tier_q_nxt  = r_tier_q;
    w_muxsel_nxt  = r_muxsel;
    w_load_nxt    = 1'b0;
    w_tierchg_nxt = 1'b0;
    w_cnt_en      = 1'b0;
    w_cnt_clr     = 1'b0;

    if (SC_SPEEDSCHED_CLEAR_InHigh) begin
      w_state_nxt  = IDLE;
      w_tier_q_nxt = '0;
      w_muxsel_nxt = '0;
      w_cnt_clr    = 1'b1;
    end else begin
      case (r_state)
        IDLE: begin
          w_cnt_clr = 1'b1;
          if (!SC_SPEEDSCHED_START_InLow) begin
            w_tier_q_nxt = w_tier;
            w_muxsel_nxt = w_onehot;
            w_state_nxt  = w_beyond ? DONE : RUN;
          end
        end
        RUN, PAUSE: begin
          if (w_beyond) begin
            w_state_nxt = DONE;
            w_cnt_clr   = 1'b1;
          end else if (w_tier != r_tier_q) begin
            // Tier change outranks pause and terminal count; state is kept.
            w_tier_q_nxt  = w_tier;
            w_muxsel_nxt  = w_onehot;
            w_tierchg_nxt = 1'b1;
            w_cnt_clr     = 1'b1;
          end else if (r_state == PAUSE) begin
            if (!SC_SPEEDSCHED_PAUSE_InHigh) begin
              w_state_nxt = RUN;
            end
          end else if (SC_SPEEDSCHED_PAUSE_InHigh) begin
            w_state_nxt = PAUSE;
          end else begin
            w_cnt_en   = 1'b1;
            w_load_nxt = w_tc;
          end
        end
        DONE: begin
          w_cnt_clr = 1'b1;
        end
        default: begin
          w_state_nxt = IDLE;
          w_cnt_clr   = 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge SC_SPEEDSCHED_CLOCK_50 or negedge SC_SPEEDSCHED_RESET_InLow) begin
    if (!SC_SPEEDSCHED_RESET_InLow) begin
      r_state   <= IDLE;
      r_tier_q  <= '0;
      r_muxsel  <= '0;
      r_load    <= 1'b0;
      r_tierchg <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_tier_q  <= w_tier_q_nxt;
      r_muxsel  <= w_muxsel_nxt;
      r_load    <= w_load_nxt;
      r_tierchg <= w_tierchg_nxt;
    end
  end

  assign SC_SPEEDSCHED_LOAD_OutHigh    = r_load;
  assign SC_SPEEDSCHED_TIERCHG_OutHigh = r_tierchg;
  assign SC_SPEEDSCHED_MUXSEL          = r_muxsel;
  assign SC_SPEEDSCHED_TIER            = r_tier_q;
  assign SC_SPEEDSCHED_RUNNING_OutHigh = (r_state == RUN) || (r_state == PAUSE);
  assign SC_SPEEDSCHED_DONE_OutHigh    = (r_state == DONE);

endmodule

`default_nettype wire

// File: tb/tb_sc_speed_scheduler.sv
// ============================================================================
// tb_sc_speed_scheduler : directed scoreboard bench, tiers {<=2,<=5,<=7}, periods {4,3,2}
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_sc_speed_scheduler;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start_n;
  logic       clear;
  logic       pause;
  logic       boost;
  logic [7:0] level;
  logic       load, tchg, running, done;
  logic [2:0] muxsel, tier;

  always #5 clk = ~clk;

  sc_speed_scheduler #(
    .TIERS          (3),
    .LEVEL_WIDTH    (8),
    .PERIOD_WIDTH   (32),
    .TIER_MAX_LEVEL ({8'd7, 8'd5, 8'd2}),
    .TIER_PERIOD    ({32'd2, 32'd3, 32'd4})
  ) dut (
    .SC_SPEEDSCHED_CLOCK_50        (clk),
    .SC_SPEEDSCHED_RESET_InLow     (rst_n),
    .SC_SPEEDSCHED_START_InLow     (start_n),
    .SC_SPEEDSCHED_CLEAR_InHigh    (clear),
    .SC_SPEEDSCHED_PAUSE_InHigh    (pause),
`ifdef SC_SPEEDSCHED_BOOST_EN
    .SC_SPEEDSCHED_BOOST_InHigh    (boost),
`endif
    .SC_SPEEDSCHED_LEVEL           (level),
    .SC_SPEEDSCHED_LOAD_OutHigh    (load),
    .SC_SPEEDSCHED_MUXSEL          (muxsel),
    .SC_SPEEDSCHED_TIER            (tier),
    .SC_SPEEDSCHED_TIERCHG_OutHigh (tchg),
    .SC_SPEEDSCHED_RUNNING_OutHigh (running),
    .SC_SPEEDSCHED_DONE_OutHigh    (done)
  );

  // Observed bundle: {LOAD, TIERCHG, RUNNING, DONE, MUXSEL[2:0], TIER[2:0]}
  logic [9:0] act;
  assign act = {load, tchg, running, done, muxsel, tier};

  int         cyc_n = 0;
  int         n_cmp = 0;
  int         n_err = 0;
  int         tag_q[$];
  logic [9:0] exp_q[$];
  string      nm_q[$];

  always @(posedge clk) cyc_n <= cyc_n + 1;

  function automatic logic [9:0] ex(input logic l, input logic t, input logic r,
                                    input logic d, input logic [2:0] m, input logic [2:0] ti);
    return {l, t, r, d, m, ti};
  endfunction

  // Sets inputs for the next edge and records what must follow that edge.
  task automatic cyc(input string nm, input logic sn, input logic cl, input logic pz,
                     input logic [7:0] lv, input logic [9:0] e);
    start_n = sn;
    clear   = cl;
    pause   = pz;
    level   = lv;
    tag_q.push_back(cyc_n + 1);
    exp_q.push_back(e);
    nm_q.push_back(nm);
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    while (tag_q.size() > 0 && tag_q[0] <= cyc_n) begin
      int         t;
      logic [9:0] e;
      string      nm;
      t  = tag_q.pop_front();
      e  = exp_q.pop_front();
      nm = nm_q.pop_front();
      n_cmp++;
      if (t != cyc_n || act !== e) begin
        n_err++;
        $display("FAIL %s cycle=%0d got=%b expected=%b (L,T,R,D,MUX,TIER)", nm, cyc_n, act, e);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1);
  end

  localparam logic [9:0] Z = 10'b0;

  initial begin
    rst_n   = 1'b0;
    start_n = 1'b1;
    clear   = 1'b0;
    pause   = 1'b0;
    boost   = 1'b0;
    level   = 8'd0;
    @(posedge clk);
    #1;

    for (int i = 0; i < 3; i++) cyc("rst_hold", 1, 0, 0, 0, Z);
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) cyc("idle", 1, 0, 0, 0, Z);

    // Tier 0, period 4
    cyc("start", 0, 0, 0, 1, ex(0, 0, 1, 0, 3'b001, 3'd0));
    for (int n = 1; n <= 11; n++) cyc("t0_run", 1, 0, 0, 1, ex(n % 4 == 0, 0, 1, 0, 3'b001, 3'd0));

    // Change to tier 1 exactly on a terminal count: LOAD suppressed
    cyc("chg_on_tc", 1, 0, 0, 3, ex(0, 1, 1, 0, 3'b010, 3'd1));
    for (int n = 1; n <= 3; n++) cyc("t1_run", 1, 0, 0, 3, ex(n == 3, 0, 1, 0, 3'b010, 3'd1));

    // Back to tier 0, pause at counter=1
    cyc("chg_back", 1, 0, 0, 1, ex(0, 1, 1, 0, 3'b001, 3'd0));
    cyc("t0_run", 1, 0, 0, 1, ex(0, 0, 1, 0, 3'b001, 3'd0));
    for (int i = 0; i < 5; i++) cyc("paused", 1, 0, 1, 1, ex(0, 0, 1, 0, 3'b001, 3'd0));
    cyc("resume", 1, 0, 0, 1, ex(0, 0, 1, 0, 3'b001, 3'd0));
    for (int n = 1; n <= 3; n++) cyc("post_pause", 1, 0, 0, 1, ex(n == 3, 0, 1, 0, 3'b001, 3'd0));

    // Tier change while paused
    cyc("pause2", 1, 0, 1, 1, ex(0, 0, 1, 0, 3'b001, 3'd0));
    cyc("pause_chg", 1, 0, 1, 3, ex(0, 1, 1, 0, 3'b010, 3'd1));
    cyc("pause2_hold", 1, 0, 1, 3, ex(0, 0, 1, 0, 3'b010, 3'd1));
    cyc("resume2", 1, 0, 0, 3, ex(0, 0, 1, 0, 3'b010, 3'd1));
    for (int n = 1; n <= 3; n++) cyc("t1_run2", 1, 0, 0, 3, ex(n == 3, 0, 1, 0, 3'b010, 3'd1));

    // Tier 2, period 2, then beyond the last tier
    cyc("chg_t2", 1, 0, 0, 6, ex(0, 1, 1, 0, 3'b100, 3'd2));
    for (int n = 1; n <= 4; n++) cyc("t2_run", 1, 0, 0, 6, ex(n % 2 == 0, 0, 1, 0, 3'b100, 3'd2));
    cyc("beyond", 1, 0, 0, 8, ex(0, 0, 0, 1, 3'b100, 3'd2));
    cyc("done_start_ign", 0, 0, 0, 8, ex(0, 0, 0, 1, 3'b100, 3'd2));
    cyc("done_level_ign", 1, 0, 0, 1, ex(0, 0, 0, 1, 3'b100, 3'd2));
    cyc("clear", 1, 1, 0, 1, Z);
    cyc("idle_after_clr", 1, 0, 0, 1, Z);

    // Asynchronous reset mid-RUN with counter=2
    cyc("start2", 0, 0, 0, 1, ex(0, 0, 1, 0, 3'b001, 3'd0));
    cyc("t0_cnt1", 1, 0, 0, 1, ex(0, 0, 1, 0, 3'b001, 3'd0));
    cyc("t0_cnt2", 1, 0, 0, 1, ex(0, 0, 1, 0, 3'b001, 3'd0));
    #5;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (act !== Z) begin
      n_err++;
      $display("FAIL async_rst got=%b expected=%b", act, Z);
    end
    @(posedge clk);
    #1;
    cyc("rst_hold2", 1, 0, 0, 1, Z);
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) cyc("rst_release", 1, 0, 0, 1, Z);

`ifdef SC_SPEEDSCHED_BOOST_EN
    // Boost halves tier 0 period 4 to 2
    boost = 1'b1;
    cyc("boost_start", 0, 0, 0, 1, ex(0, 0, 1, 0, 3'b001, 3'd0));
    for (int n = 1; n <= 4; n++) cyc("boost_run", 1, 0, 0, 1, ex(n % 2 == 0, 0, 1, 0, 3'b001, 3'd0));
`endif

    repeat (3) @(posedge clk);
    #1;
    n_cmp++;
    if (tag_q.size() != 0) begin
      n_err++;
      $display("FAIL leftover_expectations got=%0d expected=0", tag_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
